// File: rtl/credit_rx_endpoint_if.sv
// Valid/credit link plus the local ready/valid consumer port of the receiver.
interface credit_rx_endpoint_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  link_valid;
    logic [DATA_WIDTH-1:0] link_data;
    logic                  link_credit;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;

    // receiver side
    modport slave (
        input  link_valid, link_data, out_ready,
        output link_credit, out_valid, out_data
    );

    // transmitter/consumer side
    modport master (
        output link_valid, link_data, out_ready,
        input  link_credit, out_valid, out_data
    );
endinterface

// File: rtl/credit_rx_endpoint.sv
// Credit link receiver: buffers incoming beats in a DEPTH-entry circular FIFO,
// grants DEPTH initial credits after reset, then returns one credit per pop.
module credit_rx_endpoint #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 7,
    parameter int CREDIT_FFS = 2,
    localparam int OCC_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    credit_rx_endpoint_if.slave  bus,
    output logic [OCC_W-1:0]     occupancy,
    output logic                 init_done,
    output logic                 overflow_err
);
    localparam int               PTR_W = $clog2(DEPTH);
    localparam logic [OCC_W-1:0] FULL  = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t                        state, state_nxt;
    logic [OCC_W-1:0]              init_cnt, init_cnt_nxt;
    logic                          credit_in;
    logic                          pop, push, full;
    logic [PTR_W-1:0]              rd_ptr, wr_ptr;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
    logic [CREDIT_FFS-1:0]         credit_pipe;

    assign init_done       = (state == RUN);
    // head is hidden during INIT so no credit from a pop can collide with an init credit
    assign bus.out_valid   = (occupancy != '0) && init_done;
    assign bus.out_data    = mem[rd_ptr];
    assign pop             = bus.out_valid && bus.out_ready;
    assign full            = (occupancy == FULL);
    // a simultaneous pop frees the slot, so a full FIFO still takes the beat
    assign push            = bus.link_valid && (!full || pop);
    assign bus.link_credit = credit_pipe[CREDIT_FFS-1];

    // state and init-credit counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= INIT;
            init_cnt <= FULL;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    // next state and credit source: one credit per cycle in INIT, one per pop in RUN
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        credit_in    = 1'b0;
        case (state)
            INIT: begin
                credit_in    = 1'b1;
                init_cnt_nxt = init_cnt - 1'b1;
                if (init_cnt == OCC_W'(1)) state_nxt = RUN;
            end
            RUN: begin
                credit_in = pop;
            end
            default: state_nxt = INIT;
        endcase
    end

    // credit return pipeline
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            credit_pipe <= '0;
        end else begin
            credit_pipe[0] <= credit_in;
            for (int i = 1; i < CREDIT_FFS; i++) credit_pipe[i] <= credit_pipe[i-1];
        end
    end

    // FIFO storage, pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem          <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            occupancy    <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.link_data;
                wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
            if (bus.link_valid && full && !pop) overflow_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_credit_rx_endpoint.sv
// Directed bench for credit_rx_endpoint (DATA_WIDTH=8, DEPTH=7, CREDIT_FFS=2).
// Inputs change and outputs are sampled at the negedge; cycle k is the period
// ending at posedge k, with cycle 0 starting at reset release.
module tb_credit_rx_endpoint;
    localparam int DW    = 8;
    localparam int DEPTH = 7;
    localparam int CFF   = 2;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [OCC_W-1:0] occupancy;
    logic             init_done;
    logic             overflow_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int cred_cnt = 0;

    always #5 clk = ~clk;

    credit_rx_endpoint_if #(.DATA_WIDTH(DW)) bus ();

    credit_rx_endpoint #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CREDIT_FFS(CFF)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .occupancy    (occupancy),
        .init_done    (init_done),
        .overflow_err (overflow_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (bus.link_credit) cred_cnt++;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
        bus.link_valid = v;
        bus.link_data  = d;
        bus.out_ready  = r;
    endtask

    // called at a negedge: asserts reset, checks cleared outputs, releases at a later negedge
    task automatic do_reset();
        reset_n = 1'b0;
        drive(1'b0, '0, 1'b0);
        #1;
        chk("rst_occ",      32'(occupancy),     0);
        chk("rst_valid",    32'(bus.out_valid), 0);
        chk("rst_data",     32'(bus.out_data),  0);
        chk("rst_credit",   32'(bus.link_credit), 0);
        chk("rst_init",     32'(init_done),     0);
        chk("rst_overflow", 32'(overflow_err),  0);
        repeat (2) @(negedge clk);
        reset_n  = 1'b1;
        cyc      = 0;
        cred_cnt = 0;
    endtask

    // idle link after release: credits in cycles 2..8, init_done from cycle 7
    task automatic init_check();
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("init_credit", 32'(bus.link_credit), 32'(cyc >= 2 && cyc <= 8));
            chk("init_done",   32'(init_done),       32'(cyc >= 7));
        end
        chk("init_credit_total", 32'(cred_cnt), 7);
        chk("init_occ", 32'(occupancy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0]    pat;
        logic [DW-1:0] exp_q [7];
        int            exp_n, sent;
        logic          r, v;

        pat = 4'b1101;
        drive(1'b0, '0, 1'b1);
        @(negedge clk);
        do_reset();
        init_check();

        // single beat in cycle 20, popped in 21, credit in 23
        bus.out_ready = 1'b1;
        while (cyc < 20) step();
        drive(1'b1, 8'hA5, 1'b1);
        step();
        drive(1'b0, '0, 1'b1);
        chk("one_valid", 32'(bus.out_valid), 1);
        chk("one_data",  32'(bus.out_data),  8'hA5);
        chk("one_occ",   32'(occupancy),     1);
        step();
        chk("one_occ_after", 32'(occupancy), 0);
        chk("one_credit_22", 32'(bus.link_credit), 0);
        step();
        chk("one_credit_23", 32'(bus.link_credit), 1);
        step();
        chk("one_credit_24", 32'(bus.link_credit), 0);

        // 20-beat stream with out_ready pattern 1,0,1,1 wraps the pointers
        cred_cnt = 0;
        exp_n = 0;
        sent  = 0;
        for (int k = 0; k < 80 && exp_n < 20; k++) begin
            r = pat[k % 4];
            v = (sent < 20);
            drive(v, DW'(sent), r);
            if (bus.out_valid && r) begin
                chk("stream_data", 32'(bus.out_data), 32'(exp_n));
                exp_n++;
            end
            if (v) sent++;
            step();
        end
        chk("stream_count", 32'(exp_n), 20);
        drive(1'b0, '0, 1'b0);
        repeat (4) step();
        chk("stream_credits",  32'(cred_cnt),     20);
        chk("stream_occ",      32'(occupancy),    0);
        chk("stream_overflow", 32'(overflow_err), 0);

        // fill to full with consumer stalled, then overflow with 0xFF
        cred_cnt = 0;
        for (int i = 1; i <= 7; i++) begin
            drive(1'b1, DW'(i), 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b0);
        step();
        step();
        chk("fill_occ",      32'(occupancy),    7);
        chk("fill_credits",  32'(cred_cnt),     0);
        chk("fill_overflow", 32'(overflow_err), 0);
        drive(1'b1, 8'hFF, 1'b0);
        step();
        drive(1'b0, '0, 1'b0);
        chk("ovf_flag", 32'(overflow_err), 1);
        chk("ovf_occ",  32'(occupancy),    7);
        for (int i = 1; i <= 7; i++) begin
            drive(1'b0, '0, 1'b1);
            chk("drain_valid", 32'(bus.out_valid), 1);
            chk("drain_data",  32'(bus.out_data),  32'(i));
            step();
        end
        drive(1'b0, '0, 1'b0);
        chk("drain_empty", 32'(bus.out_valid), 0);
        chk("drain_occ",   32'(occupancy),     0);
        repeat (3) step();
        chk("drain_credits", 32'(cred_cnt),     7);
        chk("ovf_sticky",    32'(overflow_err), 1);

        // fresh reset; beat during INIT is held until init_done
        do_reset();
        while (cyc < 4) step();
        drive(1'b1, 8'h3C, 1'b1);
        step();
        drive(1'b0, '0, 1'b1);
        chk("early_occ",   32'(occupancy),     1);
        chk("early_hid5",  32'(bus.out_valid), 0);
        step();
        chk("early_hid6",  32'(bus.out_valid), 0);
        step();
        drive(1'b1, 8'h41, 1'b0);
        chk("early_init",  32'(init_done),     1);
        chk("early_valid", 32'(bus.out_valid), 1);
        chk("early_data",  32'(bus.out_data),  8'h3C);
        step();
        drive(1'b1, 8'h42, 1'b0);
        step();
        drive(1'b1, 8'h43, 1'b1);
        step();
        drive(1'b0, '0, 1'b0);
        chk("mid_occ",  32'(occupancy),    3);
        chk("mid_head", 32'(bus.out_data), 8'h41);
        step();
        chk("mid_credit", 32'(bus.link_credit), 1);
        // reset mid-operation with an in-flight credit
        do_reset();
        init_check();

        // full FIFO with simultaneous push and pop
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, DW'(8'h11 + i), 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b0);
        step();
        chk("pp_full", 32'(occupancy), 7);
        drive(1'b1, 8'h55, 1'b1);
        chk("pp_head", 32'(bus.out_data), 8'h11);
        step();
        drive(1'b0, '0, 1'b0);
        chk("pp_overflow", 32'(overflow_err), 0);
        chk("pp_occ",      32'(occupancy),    7);
        exp_q = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h55};
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, '0, 1'b1);
            chk("pp_data", 32'(bus.out_data), 32'(exp_q[i]));
            step();
        end
        drive(1'b0, '0, 1'b0);
        chk("pp_occ_end",      32'(occupancy),    0);
        chk("pp_overflow_end", 32'(overflow_err), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
